multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main multicycle control state machine, directly upstream of the conditional-logic stage.
//  Decodes Op/Funct (currentInstr[16:12]) and sequences each instruction through
//  fetch/decode/execute/memory/writeback states.
//  Produces the unconditioned PCS, RegW, MemW, NoWrite and FlagW that the conditional
//  logic later qualifies with CondEx, plus the datapath mux selects.
//  Memory accesses use a req/ready handshake with a timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max wait cycles for mem_ready in any memory state; counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk            in   1  clock, rising edge
//  reset          in   1  synchronous, active-high
//  Op             in   2  currentInstr[16:15]: 00 data, 01 memory, 10 branch, 11 illegal
//  Funct          in   3  currentInstr[14:12]: data {I,Instr[1:0]}; mem {x,x,L/S}; branch {B,x,x}
//  mem_ready      in   1  memory completes current access this cycle
//  mem_req        out  1  memory access request (held until mem_ready or timeout)
//  IRWrite        out  1  latch fetched instruction
//  AdrSrc         out  1  0: PC address, 1: ALU result address
//  ALUSrcA        out  1  0: register A, 1: PC
//  ALUSrcB        out  2  00 reg B, 01 immediate, 10 constant 1
//  ALUControl     out  2  00 ADD, 01 SUB, 10 AND, 11 pass-B
//  ResultSrc      out  2  00 ALUOut, 01 ReadData, 10 ALU result direct
//  NextPC         out  1  unconditional PC update (PC+1)
//  PCS            out  1  branch request to conditional logic
//  RegW           out  1  register write request
//  MemW           out  1  data memory write request
//  NoWrite        out  1  suppress register write (compare)
//  FlagW          out  2  [1] NZ update, [0] CV update
//  bus_error      out  1  one-cycle pulse on memory timeout
//  illegal_instr  out  1  one-cycle pulse on Op==11
// BEHAVIOUR
//  - Reset (sync): state=FETCH, wait counter=0; while reset high all outputs 0.
//  - Outputs are Moore, decoded from state; outputs marked "gated" are ANDed with mem_ready.
//  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
//    IRWrite and NextPC are gated. mem_ready=1 -> DECODE; else stay.
//  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00 (branch target precompute).
//    Op 00: Funct[2]=0 -> EXECR, Funct[2]=1 -> EXECI.
//    Op 01 -> MEMADR. Op 10 -> BRANCH. Op 11 -> FETCH with illegal_instr pulse.
//  - EXECR/EXECI: ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI). Then -> ALUWB.
//    ALUControl per Funct[1:0]: 00 ADD, 01 SUB, 10 AND, 11 CMP (SUB).
//  - ALUWB: ResultSrc=00, RegW=1, then -> FETCH.
//    FlagW: ADD/SUB/CMP=11, AND=10. NoWrite=1 only for CMP.
//  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00.
//    Funct[0]=0 -> MEMREAD (LDR); Funct[0]=1 -> MEMWRITE (STR).
//  - MEMREAD: mem_req=1, AdrSrc=1. mem_ready -> MEMWB; else stay.
//  - MEMWB: ResultSrc=01, RegW=1, then -> FETCH.
//  - MEMWRITE: mem_req=1, AdrSrc=1, MemW gated. mem_ready -> FETCH.
//  - BRANCH: PCS=1, ResultSrc=10, ALUSrcA=0, ALUSrcB=01. RegW=Funct[2] (link). Then -> FETCH.
//  - FlagW is 00 in every state except ALUWB. All outputs not listed for a state are 0.
//  - Wait counter:
//    - Clears on entry to any memory state and on mem_ready.
//    - Increments each cycle a memory state waits.
//    - Counter reaches TIMEOUT_CYCLES without ready -> bus_error pulse, go to FETCH (re-fetch).
//      No IRWrite, NextPC or MemW that cycle.
//  - mem_ready while mem_req=0 is ignored.
//  - mem_ready in the same cycle as a timeout: ready wins, no bus_error.
//  - Reset asserted mid-instruction aborts it; the next cycle is in FETCH, no partial write is issued.
// TESTING
//  1. Reset, then ADD reg (Op=00, Funct=000), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB, FETCH.
//     RegW=1 and FlagW=11 only in ALUWB.
//  2. CMP (Funct=011) -> ALUWB shows RegW=1, NoWrite=1, FlagW=11. AND (010) -> FlagW=10.
//  3. LDR with mem_ready low 3 cycles in MEMREAD -> mem_req held 4 cycles, then MEMWB (RegW=1, ResultSrc=01).
//  4. STR with TIMEOUT_CYCLES=4, mem_ready never -> bus_error pulse once, MemW never 1, back to FETCH.
//  5. BL (Op=10, Funct=100) -> BRANCH: PCS=1, RegW=1. Op=11 -> illegal_instr pulse, DECODE -> FETCH.
//  6. Assert reset during MEMWRITE with mem_ready=1 -> MemW=0 that cycle, state FETCH next, all outputs 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback
// and drives unconditioned write requests plus datapath mux selects.
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [2:0] Funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic [1:0] FlagW,
    output logic       bus_error,
    output logic       illegal_instr
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXECR, EXECI, ALUWB,
        MEMADR, MEMREAD, MEMWB, MEMWRITE, BRANCH
    } state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic in_mem;
    logic timeout;

    assign in_mem = (state == FETCH) || (state == MEMREAD) ||
                    (state == MEMWRITE);
    assign timeout = in_mem && !mem_ready &&
                     (cnt == CW'(TIMEOUT_CYCLES));

    // State register; reset always restarts at instruction fetch.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    // Wait counter: runs only while a memory state is stalled on ready.
    always_ff @(posedge clk) begin
        if (reset || !in_mem || mem_ready || timeout) cnt <= '0;
        else                                          cnt <= cnt + 1'b1;
    end

    // Next-state and Moore outputs; reset forces every output low.
    always_comb begin
        state_n       = state;
        mem_req       = 1'b0;
        IRWrite       = 1'b0;
        AdrSrc        = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = 2'b00;
        ResultSrc     = 2'b00;
        NextPC        = 1'b0;
        PCS           = 1'b0;
        RegW          = 1'b0;
        MemW          = 1'b0;
        NoWrite       = 1'b0;
        FlagW         = 2'b00;
        bus_error     = 1'b0;
        illegal_instr = 1'b0;
        unique case (state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
                bus_error = timeout;
                if (mem_ready) state_n = DECODE;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                unique case (Op)
                    2'b00: state_n = Funct[2] ? EXECI : EXECR;
                    2'b01: state_n = MEMADR;
                    2'b10: state_n = BRANCH;
                    default: begin
                        illegal_instr = 1'b1;
                        state_n       = FETCH;
                    end
                endcase
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl = (Funct[1:0] == 2'b11) ? 2'b01 : Funct[1:0];
                state_n    = ALUWB;
            end
            ALUWB: begin
                RegW    = 1'b1;
                FlagW   = (Funct[1:0] == 2'b10) ? 2'b10 : 2'b11;
                NoWrite = (Funct[1:0] == 2'b11);
                state_n = FETCH;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_n = Funct[0] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req   = 1'b1;
                AdrSrc    = 1'b1;
                bus_error = timeout;
                if (mem_ready)    state_n = MEMWB;
                else if (timeout) state_n = FETCH;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                state_n   = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                AdrSrc    = 1'b1;
                MemW      = mem_ready;
                bus_error = timeout;
                if (mem_ready || timeout) state_n = FETCH;
            end
            BRANCH: begin
                PCS       = 1'b1;
                ResultSrc = 2'b10;
                ALUSrcB   = 2'b01;
                RegW      = Funct[2];
                state_n   = FETCH;
            end
            default: state_n = FETCH;
        endcase
        if (reset) begin
            mem_req       = 1'b0;
            IRWrite       = 1'b0;
            AdrSrc        = 1'b0;
            ALUSrcA       = 1'b0;
            ALUSrcB       = 2'b00;
            ALUControl    = 2'b00;
            ResultSrc     = 2'b00;
            NextPC        = 1'b0;
            PCS           = 1'b0;
            RegW          = 1'b0;
            MemW          = 1'b0;
            NoWrite       = 1'b0;
            FlagW         = 2'b00;
            bus_error     = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with a short memory timeout.
// Expected output vectors are written out per state by hand.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [2:0] Funct;
    logic       mem_ready;
    logic       mem_req, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ALUControl, ResultSrc;
    logic       NextPC, PCS, RegW, MemW, NoWrite;
    logic [1:0] FlagW;
    logic       bus_error, illegal_instr;

    int total = 0;
    int bad = 0;

    multicycle_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .mem_ready(mem_ready), .mem_req(mem_req), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ResultSrc(ResultSrc), .NextPC(NextPC),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .FlagW(FlagW), .bus_error(bus_error),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    // Order: mem_req IRWrite AdrSrc ALUSrcA ALUSrcB ALUControl ResultSrc
    //        NextPC PCS RegW MemW NoWrite FlagW bus_error illegal_instr
    logic [18:0] obs;
    assign obs = {mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUControl,
                  ResultSrc, NextPC, PCS, RegW, MemW, NoWrite, FlagW,
                  bus_error, illegal_instr};

    function automatic logic [18:0] v(
        input int mr, input int irw, input int adr, input int asa,
        input int asb, input int alu, input int rs, input int npc,
        input int pcs, input int rw, input int mw, input int nw,
        input int fw, input int be, input int ill);
        logic [31:0] a [15];
        a = '{mr, irw, adr, asa, asb, alu, rs, npc, pcs, rw, mw, nw,
              fw, be, ill};
        return {a[0][0], a[1][0], a[2][0], a[3][0], a[4][1:0], a[5][1:0],
                a[6][1:0], a[7][0], a[8][0], a[9][0], a[10][0], a[11][0],
                a[12][1:0], a[13][0], a[14][0]};
    endfunction

    task automatic chk(input string tag, input logic [18:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] o,
                         input logic [2:0] f, input logic rdy);
        reset = r;
        Op = o;
        Funct = f;
        mem_ready = rdy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [18:0] ZERO, F_WAIT, F_RDY, DEC, ILL, MADR, MRD, MWB, BR;

    initial begin
        ZERO   = '0;
        F_WAIT = v(1,0,0,1,2,0,2,0,0,0,0,0,0,0,0);
        F_RDY  = v(1,1,0,1,2,0,2,1,0,0,0,0,0,0,0);
        DEC    = v(0,0,0,1,2,0,0,0,0,0,0,0,0,0,0);
        ILL    = v(0,0,0,1,2,0,0,0,0,0,0,0,0,0,1);
        MADR   = v(0,0,0,0,1,0,0,0,0,0,0,0,0,0,0);
        MRD    = v(1,0,1,0,0,0,0,0,0,0,0,0,0,0,0);
        MWB    = v(0,0,0,0,0,0,1,0,0,1,0,0,0,0,0);
        BR     = v(0,0,0,0,1,0,2,0,1,1,0,0,0,0,0);

        // reset holds all outputs low, even with mem_ready high
        drive(1, 2'b00, 3'b000, 1); chk("reset", ZERO);
        step();

        // ADD reg
        drive(0, 2'b00, 3'b000, 1); chk("add_fetch", F_RDY);
        step(); drive(0, 2'b00, 3'b000, 0); chk("add_dec", DEC);
        step(); chk("add_execr", v(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        step(); chk("add_wb", v(0,0,0,0,0,0,0,0,0,1,0,0,3,0,0));
        step(); chk("add_fetch_wait", F_WAIT);

        // CMP reg
        drive(0, 2'b00, 3'b011, 1); chk("cmp_fetch", F_RDY);
        step(); drive(0, 2'b00, 3'b011, 0); chk("cmp_dec", DEC);
        step(); chk("cmp_execr", v(0,0,0,0,0,1,0,0,0,0,0,0,0,0,0));
        step(); chk("cmp_wb", v(0,0,0,0,0,0,0,0,0,1,0,1,3,0,0));

        // AND immediate
        step(); drive(0, 2'b00, 3'b110, 1); chk("and_fetch", F_RDY);
        step(); drive(0, 2'b00, 3'b110, 0); chk("and_dec", DEC);
        step(); chk("and_execi", v(0,0,0,0,1,2,0,0,0,0,0,0,0,0,0));
        step(); chk("and_wb", v(0,0,0,0,0,0,0,0,0,1,0,0,2,0,0));

        // LDR with three stalled cycles
        step(); drive(0, 2'b01, 3'b000, 1); chk("ldr_fetch", F_RDY);
        step(); drive(0, 2'b01, 3'b000, 0); chk("ldr_dec", DEC);
        step(); chk("ldr_madr", MADR);
        for (int i = 0; i < 3; i++) begin
            step(); chk($sformatf("ldr_wait%0d", i), MRD);
        end
        step(); drive(0, 2'b01, 3'b000, 1); chk("ldr_rdy", MRD);
        step(); drive(0, 2'b01, 3'b000, 0); chk("ldr_wb", MWB);

        // STR, memory never ready: four waits then bus_error
        step(); drive(0, 2'b01, 3'b001, 1); chk("str_fetch", F_RDY);
        step(); drive(0, 2'b01, 3'b001, 0); chk("str_dec", DEC);
        step(); chk("str_madr", MADR);
        for (int i = 0; i < 4; i++) begin
            step(); chk($sformatf("str_wait%0d", i),
                        v(1,0,1,0,0,0,0,0,0,0,0,0,0,0,0));
        end
        step(); chk("str_timeout", v(1,0,1,0,0,0,0,0,0,0,0,0,0,1,0));

        // back in FETCH; ready arriving at the timeout cycle wins
        for (int i = 0; i < 4; i++) begin
            step(); chk($sformatf("refetch_wait%0d", i), F_WAIT);
        end
        step(); drive(0, 2'b10, 3'b100, 1); chk("ready_wins", F_RDY);

        // BL
        step(); drive(0, 2'b10, 3'b100, 0); chk("bl_dec", DEC);
        step(); chk("bl_branch", BR);

        // illegal opcode
        step(); drive(0, 2'b11, 3'b000, 1); chk("ill_fetch", F_RDY);
        step(); drive(0, 2'b11, 3'b000, 0); chk("ill_dec", ILL);
        step(); chk("ill_refetch", F_WAIT);

        // STR completing normally
        drive(0, 2'b01, 3'b001, 1); chk("str2_fetch", F_RDY);
        step(); drive(0, 2'b01, 3'b001, 0); chk("str2_dec", DEC);
        step(); chk("str2_madr", MADR);
        step(); drive(0, 2'b01, 3'b001, 1);
        chk("str2_write", v(1,0,1,0,0,0,0,0,0,0,1,0,0,0,0));

        // STR aborted by reset while memory is ready
        step(); chk("str3_fetch", F_RDY);
        step(); drive(0, 2'b01, 3'b001, 0); chk("str3_dec", DEC);
        step(); chk("str3_madr", MADR);
        step(); chk("str3_wait", v(1,0,1,0,0,0,0,0,0,0,0,0,0,0,0));
        drive(1, 2'b01, 3'b001, 1); chk("str3_reset", ZERO);
        step(); chk("str3_reset_hold", ZERO);
        drive(0, 2'b01, 3'b001, 0); chk("post_reset_fetch", F_WAIT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
